// File: rtl/random_pkg.sv
// rtl/random_pkg.sv - shared types, LFSR tap table and range mask helper for random_range_gen
package random_pkg;

    // Per-channel sampler state.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SAMPLE = 1'b1
    } chan_state_e;

    // Galois (right-shift) toggle masks for maximal-length sequences, width 8..32.
    // Bit i set means state bit i is toggled by the bit shifted out of bit 0.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_B400;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_B400;
        endcase
        return taps;
    endfunction

    // Smallest all-ones mask covering 0..range, i.e. 2^ceil(log2(range+1)) - 1.
    function automatic logic [31:0] range_mask(input logic [31:0] range);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 32; i++) begin
            if (mask < range) begin
                mask = {mask[30:0], 1'b1};
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/random_range_gen_if.sv
// rtl/random_range_gen_if.sv - trigger/result bundle between consumers and random_range_gen
// Optional feature macro: RANDOM_SEED_LOAD_EN adds seed_load/seed_in.
// Signals:
//   rise      - per-channel trigger, sample requested on 0->1
//   dout      - per-channel last accepted value
//   valid     - per-channel one-cycle pulse when dout updates
//   busy      - per-channel high while sampling
//   seed_load - (optional) load seed_in into the LFSR on the next edge
//   seed_in   - (optional) new LFSR state, 0 is replaced by 1
// Modports: master = consumer side, slave = generator side.
interface random_range_gen_if #(
    parameter int CHANNELS  = 2,
    parameter int SIZE_BITS = 8
`ifdef RANDOM_SEED_LOAD_EN
    ,
    parameter int LFSR_BITS = 16
`endif
);

    logic [CHANNELS-1:0]                rise;
    logic [CHANNELS-1:0][SIZE_BITS-1:0] dout;
    logic [CHANNELS-1:0]                valid;
    logic [CHANNELS-1:0]                busy;

`ifdef RANDOM_SEED_LOAD_EN
    logic                               seed_load;
    logic [LFSR_BITS-1:0]               seed_in;

    modport master (output rise, output seed_load, output seed_in,
                    input dout, input valid, input busy);
    modport slave  (input rise, input seed_load, input seed_in,
                    output dout, output valid, output busy);
`else
    modport master (output rise, input dout, input valid, input busy);
    modport slave  (input rise, output dout, output valid, output busy);
`endif

endinterface

// File: rtl/random_channel.sv
// rtl/random_channel.sv - one sampling channel: edge detect, rejection FSM, try counter, outputs
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset
//   rise_i  - trigger, sample requested on 0->1
//   cand_i  - this channel's candidate bits derived from the shared LFSR
//   dout_o  - last accepted value, holds between requests
//   valid_o - one-cycle pulse when dout_o updates
//   busy_o  - high while sampling
module random_channel
    import random_pkg::*;
#(
    parameter int SIZE_BITS = 8,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 255,
    parameter int INITIAL   = 100,
    parameter int MAX_TRIES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rise_i,
    input  logic [SIZE_BITS-1:0] cand_i,
    output logic [SIZE_BITS-1:0] dout_o,
    output logic                 valid_o,
    output logic                 busy_o
);

    localparam logic [31:0]          RANGE_W  = 32'(MAX_VAL - MIN_VAL);
    localparam logic [SIZE_BITS-1:0] RANGE_S  = SIZE_BITS'(MAX_VAL - MIN_VAL);
    localparam logic [SIZE_BITS-1:0] MASK     = SIZE_BITS'(range_mask(RANGE_W));
    localparam logic [SIZE_BITS-1:0] MIN_S    = SIZE_BITS'(MIN_VAL);
    localparam logic [SIZE_BITS-1:0] INIT_S   = SIZE_BITS'(INITIAL);
    localparam int                   TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0]     LAST_TRY = TRY_W'(MAX_TRIES - 1);

    chan_state_e          state_q;
    logic                 rise_d_q;
    logic [TRY_W-1:0]     tries_q;
    logic [SIZE_BITS-1:0] dout_q;
    logic                 valid_q;
    logic                 busy_q;

    logic [SIZE_BITS-1:0] m;
    logic                 accept;
    logic [SIZE_BITS-1:0] accept_val;
    logic [SIZE_BITS-1:0] fold_val;

    assign m          = cand_i & MASK;
    // Compared at 32 bits so a full-width range does not degenerate into a constant test.
    assign accept     = (32'(m) <= RANGE_W);
    assign accept_val = MIN_S + m;
    // Only used when m > RANGE; since m < 2*(RANGE+1) the result stays in range.
    // Wraps harmlessly when RANGE+1 overflows SIZE_BITS, as that case always accepts.
    assign fold_val   = MIN_S + (m - RANGE_S - SIZE_BITS'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rise_d_q <= 1'b0;
            tries_q  <= '0;
            dout_q   <= INIT_S;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rise_d_q <= rise_i;
            valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise_i && !rise_d_q) begin
                        state_q <= SAMPLE;
                        tries_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SAMPLE: begin
                    // Edges arriving here are intentionally dropped; there is no queueing.
                    if (accept || (tries_q == LAST_TRY)) begin
                        dout_q  <= accept ? accept_val : fold_val;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tries_q <= tries_q + TRY_W'(1);
                    end
                end
            endcase
        end
    end

    assign dout_o  = dout_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;

endmodule

// File: rtl/random_range_gen.sv
// rtl/random_range_gen.sv - shared Galois LFSR with per-channel unbiased range mapping
// Optional feature macro: RANDOM_SEED_LOAD_EN (runtime LFSR seed load via seed_load/seed_in).
// Ports:
//   clk    - system clock, all logic on posedge
//   reset  - synchronous active-high reset
//   rng_if - random_range_gen_if.slave: rise in; dout, valid, busy out;
//            seed_load/seed_in in when RANDOM_SEED_LOAD_EN is defined
module random_range_gen
    import random_pkg::*;
#(
    parameter int          SIZE_BITS = 8,
    parameter int          CHANNELS  = 2,
    parameter int          MIN_VAL   = 0,
    parameter int          MAX_VAL   = 255,
    parameter int          INITIAL   = 100,
    parameter int          LFSR_BITS = 16,
    parameter logic [31:0] SEED      = 32'h0000_ACE1,
    parameter int          MAX_TRIES = 8
) (
    input logic               clk,
    input logic               reset,
    random_range_gen_if.slave rng_if
);

    localparam logic [LFSR_BITS-1:0] TAPS   = LFSR_BITS'(lfsr_taps(LFSR_BITS));
    localparam logic [LFSR_BITS-1:0] SEED_T = LFSR_BITS'(SEED);
    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    localparam logic [LFSR_BITS-1:0] SEED_V = (SEED_T == '0) ? LFSR_BITS'(1) : SEED_T;

    logic [LFSR_BITS-1:0] lfsr_q;
    logic [LFSR_BITS-1:0] lfsr_d;

    always_comb begin
        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
`ifdef RANDOM_SEED_LOAD_EN
        if (rng_if.seed_load) begin
            lfsr_d = (rng_if.seed_in == '0) ? LFSR_BITS'(1) : rng_if.seed_in;
        end
`endif
    end

    // Free-running: steps every non-reset cycle regardless of channel activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED_V;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [SIZE_BITS-1:0] cand;

        // A channel-specific shift decorrelates channels that sample in the same cycle.
        assign cand = lfsr_q[SIZE_BITS-1:0] ^ SIZE_BITS'(lfsr_q >> (c + 1));

        random_channel #(
            .SIZE_BITS (SIZE_BITS),
            .MIN_VAL   (MIN_VAL),
            .MAX_VAL   (MAX_VAL),
            .INITIAL   (INITIAL),
            .MAX_TRIES (MAX_TRIES)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .rise_i  (rng_if.rise[c]),
            .cand_i  (cand),
            .dout_o  (rng_if.dout[c]),
            .valid_o (rng_if.valid[c]),
            .busy_o  (rng_if.busy[c])
        );
    end

endmodule

// File: tb/tb_random_range_gen.sv
// tb/tb_random_range_gen.sv - scoreboard bench for random_range_gen (full range and 10..20 instances)
// Optional feature macro: RANDOM_SEED_LOAD_EN enables the seed-load scenario.
module tb_random_range_gen;

    localparam int          CH      = 2;
    localparam int          SB      = 8;
    localparam int          LB      = 16;
    localparam int          MT      = 8;
    localparam int          INIT    = 100;
    localparam int          MIN_A   = 0;
    localparam int          MAX_A   = 255;
    localparam int          MIN_B   = 10;
    localparam int          MAX_B   = 20;
    localparam logic [15:0] TB_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 in right-shift Galois form.
    localparam logic [15:0] TB_POLY = 16'hB400;

    typedef struct packed {
        int val;
        int ev;
        int e0;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

`ifdef RANDOM_SEED_LOAD_EN
    logic              seed_load_tb = 1'b0;
    logic [LB-1:0]     seed_in_tb = '0;
    random_range_gen_if #(.CHANNELS(CH), .SIZE_BITS(SB), .LFSR_BITS(LB)) if_a ();
    random_range_gen_if #(.CHANNELS(CH), .SIZE_BITS(SB), .LFSR_BITS(LB)) if_b ();
    assign if_a.seed_load = seed_load_tb;
    assign if_a.seed_in   = seed_in_tb;
    assign if_b.seed_load = seed_load_tb;
    assign if_b.seed_in   = seed_in_tb;
`else
    random_range_gen_if #(.CHANNELS(CH), .SIZE_BITS(SB)) if_a ();
    random_range_gen_if #(.CHANNELS(CH), .SIZE_BITS(SB)) if_b ();
`endif

    random_range_gen #(
        .SIZE_BITS(SB), .CHANNELS(CH), .MIN_VAL(MIN_A), .MAX_VAL(MAX_A), .INITIAL(INIT),
        .LFSR_BITS(LB), .SEED(32'(TB_SEED)), .MAX_TRIES(MT)
    ) dut_a (.clk(clk), .reset(reset), .rng_if(if_a));

    random_range_gen #(
        .SIZE_BITS(SB), .CHANNELS(CH), .MIN_VAL(MIN_B), .MAX_VAL(MAX_B), .INITIAL(INIT),
        .LFSR_BITS(LB), .SEED(32'(TB_SEED)), .MAX_TRIES(MT)
    ) dut_b (.clk(clk), .reset(reset), .rng_if(if_b));

    logic          rise_v  [2][CH];
    logic [SB-1:0] dout_v  [2][CH];
    logic          valid_v [2][CH];
    logic          busy_v  [2][CH];

    for (genvar c = 0; c < CH; c++) begin : g_obs
        assign if_a.rise[c]  = rise_v[0][c];
        assign if_b.rise[c]  = rise_v[1][c];
        assign dout_v[0][c]  = if_a.dout[c];
        assign dout_v[1][c]  = if_b.dout[c];
        assign valid_v[0][c] = if_a.valid[c];
        assign valid_v[1][c] = if_b.valid[c];
        assign busy_v[0][c]  = if_a.busy[c];
        assign busy_v[1][c]  = if_b.busy[c];
    end

    // Reference LFSR sequence and edge counter.
    logic [15:0] m_lfsr;
    int          cyc = 0;

    function automatic logic [15:0] step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ TB_POLY) : (v >> 1);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) m_lfsr <= TB_SEED;
`ifdef RANDOM_SEED_LOAD_EN
        else if (seed_load_tb) m_lfsr <= (seed_in_tb == '0) ? 16'd1 : seed_in_tb;
`endif
        else m_lfsr <= step(m_lfsr);
    end

    // Rejection sampling over the future LFSR values: value t is the one seen by test t.
    function automatic void predict(input logic [15:0] cur, input int ch, input int lo,
                                    input int hi, output int val, output int tries);
        int          range;
        int          mask;
        int          m;
        logic [15:0] l;
        logic [15:0] cand;
        range = hi - lo;
        mask  = 0;
        while (mask < range) mask = mask * 2 + 1;
        l     = cur;
        m     = 0;
        val   = 0;
        tries = MT;
        for (int t = 1; t <= MT; t++) begin
            l    = step(l);
            cand = (l ^ (l >> (ch + 1))) & 16'h00FF;
            m    = int'(cand) & mask;
            if (m <= range) begin
                val   = lo + m;
                tries = t;
                return;
            end
        end
        val = lo + m - (range + 1);
    endfunction

    exp_t q       [2][CH][$];
    int   last_ev [2][CH];
    int   pushes  [2][CH];
    int   vcount  [2][CH];
    bit   seen_b  [256];
    int   total = 0;
    int   bad = 0;
    exp_t mon_e;

    function automatic int pending();
        int s;
        s = 0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) s += q[d][c].size();
        return s;
    endfunction

    // Called on a negedge with rise low in the previous cycle.
    task automatic pulse(input int d, input int ch, input int w, input int g);
        int n, val, t, lo, hi;
        n  = cyc;
        lo = (d == 0) ? MIN_A : MIN_B;
        hi = (d == 0) ? MAX_A : MAX_B;
        if (n + 1 > last_ev[d][ch]) begin
            predict(m_lfsr, ch, lo, hi, val, t);
            q[d][ch].push_back('{val: val, ev: n + 1 + t, e0: n + 1});
            last_ev[d][ch] = n + 1 + t;
            pushes[d][ch]++;
        end
        rise_v[d][ch] = 1'b1;
        repeat (w) @(negedge clk);
        rise_v[d][ch] = 1'b0;
        repeat (g) @(negedge clk);
    endtask

    task automatic chan_loop(input int d, input int ch, input int target, input int max_iter);
        int start;
        start = pushes[d][ch];
        for (int i = 0; i < max_iter && (pushes[d][ch] - start) < target; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse(d, ch, $urandom_range(1, 3), $urandom_range(1, 2));
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (pending() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (pending() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending=%0d required=0", pending());
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                total += 3;
                if (dout_v[d][c] !== SB'(INIT)) begin
                    bad++;
                    $display("FAIL %s_dout d%0d ch%0d got=%0d exp=%0d", tag, d, c, dout_v[d][c], INIT);
                end
                if (valid_v[d][c] !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_valid d%0d ch%0d got=%b exp=0", tag, d, c, valid_v[d][c]);
                end
                if (busy_v[d][c] !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_busy d%0d ch%0d got=%b exp=0", tag, d, c, busy_v[d][c]);
                end
            end
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) begin
                q[d][c].delete();
                last_ev[d][c] = 0;
            end
    endtask

    // Monitor: pops the expected response whenever a channel presents valid.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < CH; c++) begin
                    if (valid_v[d][c] === 1'b1) begin
                        vcount[d][c]++;
                        total++;
                        if (q[d][c].size() == 0) begin
                            bad++;
                            $display("FAIL unexpected_valid d%0d ch%0d cyc=%0d dout=%0d", d, c, cyc, dout_v[d][c]);
                        end else begin
                            mon_e = q[d][c].pop_front();
                            if (int'(dout_v[d][c]) != mon_e.val) begin
                                bad++;
                                $display("FAIL value d%0d ch%0d got=%0d exp=%0d", d, c, dout_v[d][c], mon_e.val);
                            end
                            total++;
                            if (cyc != mon_e.ev) begin
                                bad++;
                                $display("FAIL latency d%0d ch%0d got_edges=%0d exp_edges=%0d", d, c, cyc - mon_e.e0 + 1, mon_e.ev - mon_e.e0 + 1);
                            end
                            if (d == 1) begin
                                total += 2;
                                if (int'(dout_v[d][c]) < MIN_B || int'(dout_v[d][c]) > MAX_B) begin
                                    bad++;
                                    $display("FAIL range ch%0d got=%0d exp=%0d..%0d", c, dout_v[d][c], MIN_B, MAX_B);
                                end
                                if (cyc - mon_e.e0 + 1 > MT + 1) begin
                                    bad++;
                                    $display("FAIL max_latency ch%0d got=%0d exp<=%0d", c, cyc - mon_e.e0 + 1, MT + 1);
                                end
                                seen_b[dout_v[d][c]] = 1'b1;
                            end
                        end
                    end
                    total++;
                    if (busy_v[d][c] !== ((q[d][c].size() != 0) && (q[d][c][0].e0 <= cyc))) begin
                        bad++;
                        $display("FAIL busy d%0d ch%0d cyc=%0d got=%b", d, c, cyc, busy_v[d][c]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, pending());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, v1, t0, t1, k, vc, nseen;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) begin
                rise_v[d][c]  = 1'b0;
                last_ev[d][c] = 0;
                pushes[d][c]  = 0;
                vcount[d][c]  = 0;
            end

        // Reset held three cycles.
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // Single pulse, full range: valid two edges after the rise edge, channel 1 untouched.
        pulse(0, 0, 1, 1);
        repeat (4) @(negedge clk);
        total++;
        if (dout_v[0][1] !== SB'(INIT)) begin
            bad++;
            $display("FAIL ch1_unchanged got=%0d exp=%0d", dout_v[0][1], INIT);
        end
        drain();

        // Simultaneous rise on both channels at a point where the two candidates differ.
        k = 0;
        do begin
            @(negedge clk);
            predict(m_lfsr, 0, MIN_A, MAX_A, v0, t0);
            predict(m_lfsr, 1, MIN_A, MAX_A, v1, t1);
            k++;
        end while (v0 == v1 && k < 50);
        fork
            pulse(0, 0, 1, 1);
            pulse(0, 1, 1, 1);
        join
        @(negedge clk);
        total++;
        if (dout_v[0][0] === dout_v[0][1]) begin
            bad++;
            $display("FAIL simul_differ ch0=%0d ch1=%0d exp=distinct", dout_v[0][0], dout_v[0][1]);
        end
        drain();

        // Narrow range: pick a request that needs a retry, then a second edge while busy, then hold high.
        k = 0;
        do begin
            @(negedge clk);
            predict(m_lfsr, 0, MIN_B, MAX_B, v0, t0);
            k++;
        end while (t0 < 2 && k < 500);
        total++;
        if (t0 < 2) begin
            bad++;
            $display("FAIL retry_search got_tries=%0d exp>=2", t0);
        end
        vc = vcount[1][0];
        pulse(1, 0, 1, 1);
        pulse(1, 0, 50, 2);
        drain();
        total++;
        if (vcount[1][0] - vc != 1) begin
            bad++;
            $display("FAIL hold_single_valid got=%0d exp=1", vcount[1][0] - vc);
        end

        // Randomized traffic on all channels of both instances.
        fork
            chan_loop(1, 0, 1000, 4000);
            chan_loop(1, 1, 1000, 4000);
            chan_loop(0, 0, 200, 800);
            chan_loop(0, 1, 200, 800);
        join
        drain();
        total++;
        if (pushes[1][0] + pushes[1][1] < 2000) begin
            bad++;
            $display("FAIL trigger_count got=%0d exp>=2000", pushes[1][0] + pushes[1][1]);
        end
        nseen = 0;
        for (int v = MIN_B; v <= MAX_B; v++) nseen += seen_b[v] ? 1 : 0;
        total++;
        if (nseen != MAX_B - MIN_B + 1) begin
            bad++;
            $display("FAIL values_seen got=%0d exp=%0d", nseen, MAX_B - MIN_B + 1);
        end

        // Reset asserted in the first SAMPLE cycle: request abandoned.
        pulse(0, 0, 1, 0);
        reset = 1'b1;
        clear_model();
        @(negedge clk);
        check_reset_state("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total += 2;
        if (dout_v[0][0] !== SB'(INIT)) begin
            bad++;
            $display("FAIL midreset_hold got=%0d exp=%0d", dout_v[0][0], INIT);
        end
        if (vcount[0][0] != pushes[0][0] - 1) begin
            bad++;
            $display("FAIL midreset_no_valid got=%0d exp=%0d", vcount[0][0], pushes[0][0] - 1);
        end

        // Post-reset sequence starts again from the seed.
        pulse(0, 0, 1, 1);
        pulse(1, 1, 1, 1);
        drain();

`ifdef RANDOM_SEED_LOAD_EN
        // Zero seed load becomes 1; a request then follows the reloaded sequence.
        seed_in_tb   = '0;
        seed_load_tb = 1'b1;
        @(negedge clk);
        seed_load_tb = 1'b0;
        pulse(0, 0, 1, 1);
        pulse(1, 0, 1, 1);
        drain();
        seed_in_tb   = 16'h1234;
        seed_load_tb = 1'b1;
        @(negedge clk);
        seed_load_tb = 1'b0;
        pulse(0, 1, 1, 1);
        drain();
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/random_range_gen.md
# random_range_gen

Multi-channel random-number source for the keyboard/game-logic layer. A shared free-running LFSR is sampled per channel on the rising edge of that channel's trigger input. Each sample is mapped without bias into [MIN_VAL, MAX_VAL] by rejection sampling, with a bounded retry count. It sits between the key-event logic and the game objects that need spawn positions, speeds or delays, and gives each consumer its own value and valid pulse.

## Interface
- SIZE_BITS, 8: output value width.
- CHANNELS, 2: independent trigger/output channels, 1..8.
- MIN_VAL, 0: inclusive lower bound of outputs.
- MAX_VAL, 255: inclusive upper bound; MIN_VAL <= MAX_VAL < 2^SIZE_BITS.
- INITIAL, 100: dout value after reset; must lie in [MIN_VAL, MAX_VAL].
- LFSR_BITS, 16: LFSR width, 8..32; must be >= SIZE_BITS + CHANNELS.
- SEED, 16'hACE1: LFSR reset value; 0 is replaced by 1.
- MAX_TRIES, 8: rejection attempts before the fold fallback, >= 1.
- clk  in  1  single system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- rise  in  CHANNELS  per-channel trigger; a sample is requested on a 0->1 transition.
- dout  out  CHANNELS x SIZE_BITS  last accepted value per channel.
- valid  out  CHANNELS  one-cycle pulse when that channel's dout updates.
- busy  out  CHANNELS  high while the channel is sampling.

## Operation
- LFSR: Galois, maximal-length taps from the package. It advances every cycle that reset is low, independent of channel activity.
- Per-channel candidate c: bits [SIZE_BITS-1:0] of (lfsr XOR (lfsr >> (c+1))). This decorrelates channels sampling in the same cycle.
- RANGE = MAX_VAL - MIN_VAL.
- MASK = 2^ceil(log2(RANGE+1)) - 1.
- m = candidate & MASK.
- Accept when m <= RANGE; the result is MIN_VAL + m, computed at SIZE_BITS width with no overflow by construction.
- Per-channel FSM:
  - IDLE: on rise & ~rise_d -> SAMPLE, tries = 0, busy = 1.
  - SAMPLE, m accepted: dout <= MIN_VAL + m, valid = 1 for one cycle -> IDLE, busy = 0.
  - SAMPLE, m rejected and tries < MAX_TRIES-1: tries++, stay in SAMPLE.
  - SAMPLE, m rejected on the last try: fold, dout <= MIN_VAL + (m - (RANGE+1)), valid = 1 -> IDLE. The fold result is always in range because m < 2(RANGE+1).
- rise_d registers rise every cycle in every state.
- Rising edges seen while in SAMPLE are dropped; there is no queueing.
- Rising edge on the same cycle the FSM returns to IDLE: dropped, because the FSM is in SAMPLE on that edge.
- When RANGE+1 is a power of two, rejection never occurs.
- Channels are fully independent; any number may sample in the same cycle.

## Timing
- Reset values: dout = INITIAL on all channels, valid = 0, busy = 0, FSM = IDLE, rise_d = 0, lfsr = SEED (or 1 if SEED is 0), tries = 0.
- Edge E0 registers rise=1 with rise_d=0. busy is high after E0.
- First test happens at E1. On accept, dout and valid update after E1.
- Minimum latency: 2 edges from the rise edge to valid.
- Maximum latency: MAX_TRIES+1 edges.
- valid is high for exactly one cycle per accepted request.
- dout holds its value between requests.
- Reset asserted mid-SAMPLE: the request is abandoned, no valid is produced, and all reset values apply on the next edge.

## Configuration
- RANDOM_SEED_LOAD_EN defined: adds ports seed_load (in, 1) and seed_in (in, LFSR_BITS).
  - When seed_load=1, lfsr <= seed_in on the next edge, with 0 replaced by 1.
  - A seed load takes priority over the LFSR step.
  - Channel FSMs are unaffected; a sample in flight uses the new sequence.
- Macro undefined: no extra ports; the LFSR only ever starts from SEED.

## Structure
- Package random_pkg holds:
  - LFSR tap constants indexed by width 8..32.
  - The channel state enum (IDLE, SAMPLE).
  - A range_mask(range) function.
- Sub-module random_channel holds the rise edge detection, FSM, tries counter and dout/valid/busy for one channel. It is instantiated CHANNELS times in a generate loop.
- The top level holds the LFSR and candidate derivation.

## Test plan
- Reset held 3 cycles, then released -> every dout = 100, valid = 0, busy = 0, and lfsr = 16'hACE1 at the first post-reset edge.
- Default range (0..255), single rise pulse on channel 0 -> valid[0] exactly 2 edges later, dout[0] equals the reference model's LFSR-derived value, channel 1 unchanged.
- MIN_VAL=10, MAX_VAL=20, 2000 triggers -> every output in 10..20, all 11 values observed, every latency <= MAX_TRIES+1.
- rise[0] held high 50 cycles, plus a second rise edge during busy -> exactly one valid pulse.
- Simultaneous rise on channels 0 and 1 -> both valid in the same cycle, values match the model, and the values differ for the seeds under test.
- Reset asserted at the first SAMPLE cycle -> no valid, dout = 100; with RANDOM_SEED_LOAD_EN, seed_in = 0 with seed_load -> lfsr = 1.
